// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two FIFO'd writeback requesters round-robined onto one registered RF write port; RF_WB_SCOREBOARD_EN adds busy_mask
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_grant
`ifdef RF_WB_SCOREBOARD_EN
  ,
  output logic [31:0]       busy_mask
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [1:0] in_v, push, pop, ne, full;
  logic [ADDR_W-1:0] in_a [2];
  logic [DATA_W-1:0] in_d [2];
  logic [ADDR_W-1:0] ha [2];
  logic [DATA_W-1:0] hd [2];
  logic [31:0] fbusy [2];
  logic rr;
  assign in_v = {req1_valid, req0_valid};
  assign in_a[0] = req0_addr;
  assign in_a[1] = req1_addr;
  assign in_d[0] = req0_data;
  assign in_d[1] = req1_data;
  assign req0_ready = !full[0];
  assign req1_ready = !full[1];
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [ADDR_W-1:0] ma [FIFO_DEPTH];
    logic [DATA_W-1:0] md [FIFO_DEPTH];
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] cnt;
    logic [31:0] fb;
    assign full[g] = cnt == CW'(FIFO_DEPTH);
    assign ne[g] = cnt != '0;
    // x0 writes are acknowledged but dropped here
    assign push[g] = in_v[g] && !full[g] && in_a[g] != '0;
    assign ha[g] = ma[rp];
    assign hd[g] = md[rp];
    assign fbusy[g] = fb;
    always_ff @(posedge clk)
      if (push[g]) begin
        ma[wp] <= in_a[g];
        md[wp] <= in_d[g];
      end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else begin
        if (push[g]) wp <= wp + 1'b1;
        if (pop[g]) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
      end
`ifdef RF_WB_SCOREBOARD_EN
    always_comb begin
      fb = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (CW'(i) < cnt) fb[ma[rp + PW'(i)]] = 1'b1;
    end
`else
    assign fb = '0;
`endif
  end
  // rr holds the last granted port; reset value 1 makes req0 win the first tie
  assign pop[1] = ne[1] && (!ne[0] || !rr);
  assign pop[0] = ne[0] && !pop[1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_wd <= '0;
      rf_grant <= 1'b0;
      rr <= 1'b1;
    end else begin
      rf_we <= |pop;
      if (|pop) begin
        rf_addr <= pop[1] ? ha[1] : ha[0];
        rf_wd <= pop[1] ? hd[1] : hd[0];
        rf_grant <= pop[1];
        rr <= pop[1];
      end
    end
`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] wbusy;
  always_comb begin
    wbusy = '0;
    if (rf_we) wbusy[rf_addr] = 1'b1;
  end
  assign busy_mask = (fbusy[0] | fbusy[1] | wbusy) & ~32'd1;
`else
  logic unused_fbusy;
  assign unused_fbusy = ^{fbusy[0], fbusy[1]};
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter (busy_mask checks with RF_WB_SCOREBOARD_EN)
module tb_rf_wb_arbiter;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [4:0] req0_addr = 0, req1_addr = 0, rf_addr;
  logic [31:0] req0_data = 0, req1_data = 0, rf_wd;
  logic rf_we, rf_grant;
`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] busy_mask;
`endif
  int n_cmp = 0, n_bad = 0;
  bit saw_stall1 = 0;
  typedef struct {logic g; logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t log_q[$];

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd), .rf_grant(rf_grant)
`ifdef RF_WB_SCOREBOARD_EN
    , .busy_mask(busy_mask)
`endif
  );

  always @(negedge clk) begin
    if (rst && rf_we) log_q.push_back('{rf_grant, rf_addr, rf_wd});
    if (req1_valid && !req1_ready) saw_stall1 = 1;
  end

  task automatic do_reset();
    rst = 0;
    req0_valid = 0;
    req1_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    log_q.delete();
    saw_stall1 = 0;
  endtask

  task automatic send(input int p, input logic [4:0] a, input logic [31:0] d);
    bit ok = 0;
    if (p == 0) begin req0_valid = 1; req0_addr = a; req0_data = d; end
    else begin req1_valid = 1; req1_addr = a; req1_data = d; end
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = (p == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL send_timeout p%0d addr %0d: ready never seen", p, a); end
  endtask

  task automatic idle(input int p);
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    n_cmp += 6;
    if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", rf_we); end
    if (rf_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", rf_addr); end
    if (rf_wd !== 32'd0) begin n_bad++; $display("FAIL reset_wd: got %h want 0", rf_wd); end
    if (rf_grant !== 1'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0", rf_grant); end
    do_reset();
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready0: got %b want 1", req0_ready); end
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready1: got %b want 1", req1_ready); end
`ifdef RF_WB_SCOREBOARD_EN
    n_cmp++;
    if (busy_mask !== 32'd0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
`endif
  endtask

  task automatic test_single_write();
    do_reset();
    send(0, 5'd5, 32'hDEAD_BEEF);
    idle(0);
    @(negedge clk);
    n_cmp++;
    if (rf_we !== 1'b0) begin n_bad++; $display("FAIL single_early_we: got %b want 0", rf_we); end
    @(negedge clk);
    n_cmp += 4;
    if (rf_we !== 1'b1) begin n_bad++; $display("FAIL single_we: got %b want 1", rf_we); end
    if (rf_addr !== 5'd5) begin n_bad++; $display("FAIL single_addr: got %0d want 5", rf_addr); end
    if (rf_wd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_wd: got %h want deadbeef", rf_wd); end
    if (rf_grant !== 1'b0) begin n_bad++; $display("FAIL single_grant: got %b want 0", rf_grant); end
    @(negedge clk);
    n_cmp++;
    if (rf_we !== 1'b0) begin n_bad++; $display("FAIL single_pulse_len: got %b want 0", rf_we); end
  endtask

  task automatic test_contention();
    int exp_a[6] = '{1, 4, 2, 5, 3, 6};
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    fork
      begin send(0, 1, 32'h101); send(0, 2, 32'h102); send(0, 3, 32'h103); idle(0); end
      begin send(1, 4, 32'h104); send(1, 5, 32'h105); send(1, 6, 32'h106); idle(1); end
    join
    repeat (6) @(negedge clk);
    n_cmp++;
    if (log_q.size() != 6) begin n_bad++; $display("FAIL contention_count: got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      n_cmp += 3;
      if (log_q[i].a !== 5'(exp_a[i])) begin n_bad++; $display("FAIL contention_addr[%0d]: got %0d want %0d", i, log_q[i].a, exp_a[i]); end
      if (log_q[i].g !== 1'(exp_g[i])) begin n_bad++; $display("FAIL contention_grant[%0d]: got %b want %0d", i, log_q[i].g, exp_g[i]); end
      if (log_q[i].d !== 32'h100 + exp_a[i]) begin n_bad++; $display("FAIL contention_data[%0d]: got %h want %h", i, log_q[i].d, 32'h100 + exp_a[i]); end
    end
  endtask

  task automatic test_backpressure();
    int k0 = 0, k1 = 0;
    do_reset();
    fork
      begin for (int i = 0; i < 6; i++) send(0, 5'(11 + i), 32'hA00 + i); idle(0); end
      begin for (int i = 0; i < 4; i++) send(1, 5'(21 + i), 32'hB00 + i); idle(1); end
    join
    repeat (10) @(negedge clk);
    n_cmp++;
    if (saw_stall1 !== 1'b1) begin n_bad++; $display("FAIL bp_stall: req1_ready never low, got %b want 1", saw_stall1); end
    foreach (log_q[i]) begin
      n_cmp += 2;
      if (log_q[i].g) begin
        if (log_q[i].a !== 5'(21 + k1)) begin n_bad++; $display("FAIL bp_addr1[%0d]: got %0d want %0d", k1, log_q[i].a, 21 + k1); end
        if (log_q[i].d !== 32'hB00 + k1) begin n_bad++; $display("FAIL bp_data1[%0d]: got %h want %h", k1, log_q[i].d, 32'hB00 + k1); end
        k1++;
      end else begin
        if (log_q[i].a !== 5'(11 + k0)) begin n_bad++; $display("FAIL bp_addr0[%0d]: got %0d want %0d", k0, log_q[i].a, 11 + k0); end
        if (log_q[i].d !== 32'hA00 + k0) begin n_bad++; $display("FAIL bp_data0[%0d]: got %h want %h", k0, log_q[i].d, 32'hA00 + k0); end
        k0++;
      end
    end
    n_cmp += 2;
    if (k1 != 4) begin n_bad++; $display("FAIL bp_count1: got %0d want 4", k1); end
    if (k0 != 6) begin n_bad++; $display("FAIL bp_count0: got %0d want 6", k0); end
  endtask

  task automatic test_x0_filter();
    do_reset();
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b want 1", req0_ready); end
    send(0, 5'd0, 32'h1234);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_we[%0d]: got %b want 0", i, rf_we); end
    end
    n_cmp++;
    if (log_q.size() != 0) begin n_bad++; $display("FAIL x0_writes: got %0d want 0", log_q.size()); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    fork send(0, 7, 32'h7); send(1, 17, 32'h17); join
    fork send(0, 8, 32'h8); send(1, 18, 32'h18); join
    idle(0);
    idle(1);
    n_cmp += 2;
    if (rf_we !== 1'b1) begin n_bad++; $display("FAIL mid_pre_we: got %b want 1", rf_we); end
    if (rf_addr !== 5'd7) begin n_bad++; $display("FAIL mid_pre_addr: got %0d want 7", rf_addr); end
    #2 rst = 0;
    #1;
    n_cmp += 2;
    if (rf_we !== 1'b0) begin n_bad++; $display("FAIL mid_async_we: got %b want 0", rf_we); end
    if (rf_addr !== 5'd0) begin n_bad++; $display("FAIL mid_async_addr: got %0d want 0", rf_addr); end
    @(negedge clk);
    rst = 1;
    log_q.delete();
    repeat (4) @(negedge clk);
    n_cmp += 3;
    if (log_q.size() != 0) begin n_bad++; $display("FAIL mid_stale: got %0d writes want 0", log_q.size()); end
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready0: got %b want 1", req0_ready); end
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready1: got %b want 1", req1_ready); end
  endtask

`ifdef RF_WB_SCOREBOARD_EN
  task automatic test_scoreboard();
    do_reset();
    fork send(0, 9, 32'h9); send(1, 10, 32'hA); join
    idle(0);
    idle(1);
    n_cmp++;
    if (busy_mask !== 32'h0000_0600) begin n_bad++; $display("FAIL sb_queued: got %h want 00000600", busy_mask); end
    @(posedge clk); #1;
    n_cmp += 2;
    if (rf_addr !== 5'd9) begin n_bad++; $display("FAIL sb_first_addr: got %0d want 9", rf_addr); end
    if (busy_mask !== 32'h0000_0600) begin n_bad++; $display("FAIL sb_x9_writing: got %h want 00000600", busy_mask); end
    @(posedge clk); #1;
    n_cmp++;
    if (busy_mask !== 32'h0000_0400) begin n_bad++; $display("FAIL sb_x9_cleared: got %h want 00000400", busy_mask); end
    @(posedge clk); #1;
    n_cmp++;
    if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL sb_all_cleared: got %h want 0", busy_mask); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_x0_filter();
    test_reset_midstream();
`ifdef RF_WB_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
